alu_pipe_reg: RTL and testbench

//  Parametrised, registered successor to the team's 2-bit-select logic unit.
//  - Widens operands to WIDTH bits and extends the opcode to 3 bits (logic + arithmetic + shift).
//  - Adds an internal accumulator mode, ZERO/CARRY flags and a valid/ready handshake on both sides.
//  - Sits between an operand source (FSM or switch/debounce front end) and a result consumer (display/LED driver).

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_core_comb.sv | 46 ++++
 rtl/alu_pipe_reg.sv | 89 ++++++++
 tb/tb_alu_pipe_reg.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and sizing helpers for the registered ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Bits of b used as the shift amount; WIDTH is a power of two, so every
  // encodable amount is below WIDTH.
  function automatic int shamt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/alu_core_comb.sv
// Purely combinational datapath: logic, add/sub with carry/borrow, logical shifts.
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic [WIDTH-1:0] o_y,
  output logic             o_carry
);

  localparam int SHW = shamt_width(WIDTH);

  logic [SHW-1:0] w_sh;
  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sh   = i_b[SHW-1:0];
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // The extra MSB of the difference is the unsigned borrow (a < b).
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_y     = '0;
    o_carry = 1'b0;
    case (i_op)
      OP_AND: o_y = i_a & i_b;
      OP_OR:  o_y = i_a | i_b;
      OP_XOR: o_y = i_a ^ i_b;
      OP_NOT: o_y = ~i_a;
      OP_ADD: begin
        o_y     = w_sum[WIDTH-1:0];
        o_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        o_y     = w_diff[WIDTH-1:0];
        o_carry = w_diff[WIDTH];
      end
      OP_SHL: o_y = i_a << w_sh;
      OP_SHR: o_y = i_a >> w_sh;
    endcase
  end

endmodule

// File: rtl/alu_pipe_reg.sv
// Registered ALU with accumulator mode, zero/carry flags and a one-deep output stage.
module alu_pipe_reg
  import alu_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             carry,
  output logic [WIDTH-1:0] acc
);

  // Handshake: a beat transfers on any edge where valid && ready. The output
  // stage can take a new beat when empty or when its current result leaves
  // in the same cycle; otherwise inputs are ignored and the result holds.
  logic             r_out_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_zero;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;

  // A clear on the same beat as an accumulate feeds the cleared value.
  assign w_op_a = acc_en ? (acc_clr ? ACC_INIT : r_acc) : a;

  alu_core_comb #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_a    (w_op_a),
    .i_b    (b),
    .i_op   (op),
    .o_y    (w_res),
    .o_carry(w_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_y         <= w_res;
      r_zero      <= (w_res == '0);
      r_carry     <= w_carry;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= ACC_INIT;
    end else if (w_accept && acc_en) begin
      r_acc <= w_res;
    end else if (acc_clr) begin
      r_acc <= ACC_INIT;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign zero      = r_zero;
  assign carry     = r_carry;
  assign acc       = r_acc;

endmodule

// File: tb/tb_alu_pipe_reg.sv
// Directed plus randomized bench for alu_pipe_reg against a transaction-level model.
module tb_alu_pipe_reg;

  localparam int         W        = 8;
  localparam logic [W-1:0] ACC_INIT = 8'h00;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   op;
  logic         acc_en;
  logic         acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         zero;
  logic         carry;
  logic [W-1:0] acc;

  alu_pipe_reg #(
    .WIDTH   (W),
    .ACC_INIT(ACC_INIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .acc_en   (acc_en),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .zero     (zero),
    .carry    (carry),
    .acc      (acc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int           n_chk;
  int           n_pass;
  int           n_fail;
  logic [W-1:0] exp_q[$];

  // reference model state
  logic         m_valid;
  logic [W-1:0] m_y;
  logic         m_zero;
  logic         m_carry;
  logic [W-1:0] m_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic void ref_alu(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                  input logic [2:0] rop,
                                  output logic [W-1:0] r, output logic c);
    int s;
    int sh;
    sh = int'(rb) % W;
    r  = '0;
    c  = 1'b0;
    case (rop)
      3'd0: r = ra & rb;
      3'd1: r = ra | rb;
      3'd2: r = ra ^ rb;
      3'd3: r = ~ra;
      3'd4: begin
        s = int'(ra) + int'(rb);
        r = s[W-1:0];
        c = (s > 255);
      end
      3'd5: begin
        s = int'(ra) - int'(rb) + 256;
        r = s[W-1:0];
        c = (ra < rb);
      end
      3'd6: begin
        s = (int'(ra) * (1 << sh)) % 256;
        r = s[W-1:0];
      end
      default: begin
        s = int'(ra) / (1 << sh);
        r = s[W-1:0];
      end
    endcase
  endfunction

  task automatic do_reset(input int cycles);
    rst      = 1'b1;
    in_valid = 1'b0;
    acc_en   = 1'b0;
    acc_clr  = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst     = 1'b0;
    m_valid = 1'b0;
    m_y     = '0;
    m_zero  = 1'b0;
    m_carry = 1'b0;
    m_acc   = ACC_INIT;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, check the combinational side, advance one edge,
  // then check the registered side against the model.
  task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [2:0] iop, input logic ae, input logic ac,
                      input logic orr);
    logic         rdy;
    logic [W-1:0] opa;
    logic [W-1:0] r;
    logic         c;
    logic [W-1:0] e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    op        = iop;
    acc_en    = ae;
    acc_clr   = ac;
    out_ready = orr;
    #1;
    rdy = !m_valid || orr;
    chk("in_ready", in_ready, rdy);
    if (m_valid && orr) begin
      if (exp_q.size() == 0) chk("deliver_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("deliver_y", y, e);
      end
    end
    if (iv && rdy) begin
      opa = ae ? (ac ? ACC_INIT : m_acc) : ia;
      ref_alu(opa, ib, iop, r, c);
      m_valid = 1'b1;
      m_y     = r;
      m_zero  = (r == 0);
      m_carry = c;
      exp_q.push_back(r);
      if (ae) m_acc = r;
      else if (ac) m_acc = ACC_INIT;
    end else begin
      if (orr) m_valid = 1'b0;
      if (ac) m_acc = ACC_INIT;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("y", y, m_y);
    chk("zero", zero, m_zero);
    chk("carry", carry, m_carry);
    chk("acc", acc, m_acc);
  endtask

  logic [W-1:0] tab_y [8];
  logic [W-1:0] stall_y;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    n_fail = 0;
    a = '0; b = '0; op = '0;
    tab_y = '{8'h24, 8'hBD, 8'h99, 8'h5A, 8'hE1, 8'h69, 8'h28, 8'h14};

    // 1. reset
    do_reset(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    chk("rst_acc", acc, 0);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // 2. one beat per opcode, a=0xA5 b=0x3C (shifts use b=0x03)
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'hA5, (i >= 6) ? 8'h03 : 8'h3C, 3'(i), 1'b0, 1'b0, 1'b1);
      chk($sformatf("op%0d_const", i), y, tab_y[i]);
      if (i == 4 || i == 5) chk($sformatf("op%0d_carry_const", i), carry, 0);
    end

    // 3. wrap and flags
    step(1'b1, 8'hFF, 8'h01, 3'b100, 1'b0, 1'b0, 1'b1);
    chk("add_wrap_y", y, 8'h00);
    chk("add_wrap_zero", zero, 1);
    chk("add_wrap_carry", carry, 1);
    step(1'b1, 8'h10, 8'h20, 3'b101, 1'b0, 1'b0, 1'b1);
    chk("sub_borrow_y", y, 8'hF0);
    chk("sub_borrow_carry", carry, 1);
    step(1'b1, 8'h81, 8'h00, 3'b110, 1'b0, 1'b0, 1'b1);
    chk("shl0_pass", y, 8'h81);
    step(1'b1, 8'h81, 8'h07, 3'b111, 1'b0, 1'b0, 1'b1);
    chk("shr7_max", y, 8'h01);

    // 4. stall with a pending result
    step(1'b1, 8'h0F, 8'hF0, 3'b001, 1'b0, 1'b0, 1'b1);
    stall_y = y;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h55, 8'h11, 3'b100, 1'b0, 1'b0, 1'b0);
      chk("stall_y_hold", y, stall_y);
      chk("stall_in_ready", in_ready, 0);
    end
    step(1'b1, 8'h55, 8'h11, 3'b100, 1'b0, 1'b0, 1'b1);
    chk("stall_release_y", y, 8'h66);
    step(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("drain_valid", out_valid, 0);
    chk("drain_y_hold", y, 8'h66);

    // 5. accumulator
    step(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b1, 1'b1);
    chk("acc_clr", acc, 8'h00);
    step(1'b1, 8'hEE, 8'h05, 3'b100, 1'b1, 1'b0, 1'b1);
    chk("acc_1", acc, 8'h05);
    step(1'b1, 8'hEE, 8'h05, 3'b100, 1'b1, 1'b0, 1'b1);
    chk("acc_2", acc, 8'h0A);
    step(1'b1, 8'hEE, 8'h05, 3'b100, 1'b1, 1'b0, 1'b1);
    chk("acc_3", acc, 8'h0F);
    step(1'b1, 8'hEE, 8'h05, 3'b100, 1'b1, 1'b1, 1'b1);
    chk("acc_clr_beat", acc, 8'h05);

    // 6. reset right after an accept
    step(1'b1, 8'h12, 8'h05, 3'b100, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_valid = 1'b0; m_y = '0; m_zero = 1'b0; m_carry = 1'b0; m_acc = ACC_INIT;
    exp_q.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_acc", acc, 8'h00);
    step(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1);
    chk("midrst_no_deliver", out_valid, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
